axis_vid_timing_out: RTL and testbench

//  Downstream sink for the AXI4-Stream video source: consumes one 32-bit pixel beat per

---
 rtl/video_pkg.sv | 33 +++
 rtl/video_out_fifo.sv | 51 +++++
 rtl/axis_vid_timing_out.sv | 197 +++++++++++++++++++
 tb/tb_axis_vid_timing_out.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared timing defaults, FIFO entry layout and FSM states for the raster output path.
package video_pkg;

    localparam int unsigned DEF_H_ACTIVE   = 640;
    localparam int unsigned DEF_H_FP       = 16;
    localparam int unsigned DEF_H_SYNC     = 96;
    localparam int unsigned DEF_H_BP       = 48;
    localparam int unsigned DEF_V_ACTIVE   = 480;
    localparam int unsigned DEF_V_FP       = 10;
    localparam int unsigned DEF_V_SYNC     = 2;
    localparam int unsigned DEF_V_BP       = 33;
    localparam int unsigned DEF_FIFO_DEPTH = 16;

    typedef struct packed {
        logic        tuser;
        logic        tlast;
        logic [23:0] rgb;
    } pix_entry_t;

    localparam int unsigned PIX_ENTRY_W = $bits(pix_entry_t);

    typedef enum logic [1:0] {
        WAIT_SOF,
        ARMED,
        RUN
    } vid_state_t;

    function automatic int unsigned line_total(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/video_out_fifo.sv
// First-word-fall-through pixel FIFO with synchronous flush; flush wins over a same-cycle push.
module video_out_fifo
    import video_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned WIDTH = PIX_ENTRY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees the head slot in the same cycle, so a full FIFO can still take a beat.
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/axis_vid_timing_out.sv
// AXI4-Stream video sink driving de/hsync/vsync raster timing with SOF lock and resync.
// Define VID_OUT_ERR_CNT_EN to add the saturating err_count output.
module axis_vid_timing_out
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned H_FP       = DEF_H_FP,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BP       = DEF_H_BP,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter int unsigned V_FP       = DEF_V_FP,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BP       = DEF_V_BP,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned SYNC_POL   = 0
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [31:0] s_axis_vid_tdata,
    input  logic        s_axis_vid_tvalid,
    output logic        s_axis_vid_tready,
    input  logic        s_axis_vid_tuser,
    input  logic        s_axis_vid_tlast,
    output logic [23:0] vid_data,
    output logic        vid_de,
    output logic        vid_hsync,
    output logic        vid_vsync,
    output logic        locked,
    output logic        underflow,
    output logic        line_err
`ifdef VID_OUT_ERR_CNT_EN
    ,
    output logic [15:0] err_count
`endif
);

    localparam int unsigned H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HW = $clog2(H_TOTAL);
    localparam int unsigned VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          SYNC_ACT   = (SYNC_POL != 0);

    vid_state_t    state;
    vid_state_t    state_next;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          rst_done;
    logic          active;
    logic          at_sof_pos;
    logic          frame_end;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_flush;
    logic          fifo_full;
    logic          fifo_empty;
    pix_entry_t    fifo_wr;
    pix_entry_t    head;
    logic          pix_valid;
    logic          ev_underflow;
    logic          ev_sync;
    logic          ev_line;
    logic          unused_tdata;

    assign unused_tdata = ^s_axis_vid_tdata[31:24];
    assign active       = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign at_sof_pos   = (hcnt == '0) && (vcnt == '0);
    assign frame_end    = (hcnt == H_LAST) && (vcnt == V_LAST);
    assign fifo_wr      = '{tuser: s_axis_vid_tuser, tlast: s_axis_vid_tlast,
                            rgb: s_axis_vid_tdata[23:0]};
    assign locked       = (state == RUN);

    video_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIX_ENTRY_W)
    ) u_fifo (
        .clk     (aclk),
        .rst     (areset),
        .flush   (fifo_flush),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (fifo_wr),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Holds tready low for the first cycle after reset release.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) rst_done <= 1'b0;
        else        rst_done <= 1'b1;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state <= WAIT_SOF;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            WAIT_SOF: if (rst_done && s_axis_vid_tvalid && s_axis_vid_tuser) state_next = ARMED;
            ARMED:    if (frame_end)  state_next = RUN;
            RUN:      if (fifo_flush) state_next = WAIT_SOF;
            default:  state_next = WAIT_SOF;
        endcase
    end

    always_comb begin
        s_axis_vid_tready = 1'b0;
        fifo_push         = 1'b0;
        fifo_pop          = 1'b0;
        fifo_flush        = 1'b0;
        pix_valid         = 1'b0;
        ev_underflow      = 1'b0;
        ev_sync           = 1'b0;
        ev_line           = 1'b0;
        unique case (state)
            WAIT_SOF: begin
                s_axis_vid_tready = rst_done;
                fifo_push         = s_axis_vid_tvalid && s_axis_vid_tready && s_axis_vid_tuser;
            end
            ARMED: begin
                s_axis_vid_tready = rst_done && !fifo_full;
                fifo_push         = s_axis_vid_tvalid && s_axis_vid_tready;
            end
            RUN: begin
                s_axis_vid_tready = rst_done && !fifo_full;
                if (active) begin
                    if (fifo_empty) begin
                        ev_underflow = 1'b1;
                        fifo_flush   = 1'b1;
                    end else if (head.tuser != at_sof_pos) begin
                        ev_sync    = 1'b1;
                        fifo_flush = 1'b1;
                    end else begin
                        fifo_pop  = 1'b1;
                        pix_valid = 1'b1;
                        ev_line   = (head.tlast != (hcnt == H_ACT_LAST));
                    end
                end
                fifo_push = s_axis_vid_tvalid && s_axis_vid_tready && !fifo_flush;
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            vid_data  <= '0;
            vid_de    <= 1'b0;
            vid_hsync <= ~SYNC_ACT;
            vid_vsync <= ~SYNC_ACT;
            underflow <= 1'b0;
            line_err  <= 1'b0;
        end else begin
            vid_data  <= pix_valid ? head.rgb : '0;
            vid_de    <= active;
            vid_hsync <= ((hcnt >= HS_START) && (hcnt < HS_END)) ? SYNC_ACT : ~SYNC_ACT;
            vid_vsync <= ((vcnt >= VS_START) && (vcnt < VS_END)) ? SYNC_ACT : ~SYNC_ACT;
            underflow <= underflow | ev_underflow;
            line_err  <= ev_line;
        end
    end

`ifdef VID_OUT_ERR_CNT_EN
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            err_count <= '0;
        end else if ((ev_underflow || ev_sync || ev_line) && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_vid_timing_out.sv
// Scoreboard bench for axis_vid_timing_out: a frame-level reference model predicts every output cycle.
`timescale 1ns/1ps
module tb_axis_vid_timing_out;

    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int DEPTH = 8;
    localparam int FRAME_PX = HA * VA;
    localparam int FRAME_CYC = HT * VT;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [31:0] tdata = '0;
    logic        tvalid = 1'b0;
    logic        tuser = 1'b0;
    logic        tlast = 1'b0;
    logic        tready;
    logic [23:0] vid_data;
    logic        vid_de, vid_hsync, vid_vsync, locked, underflow, line_err;
`ifdef VID_OUT_ERR_CNT_EN
    logic [15:0] err_count;
`endif

    axis_vid_timing_out #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .FIFO_DEPTH (DEPTH), .SYNC_POL (0)
    ) dut (
        .aclk              (aclk),
        .areset            (areset),
        .s_axis_vid_tdata  (tdata),
        .s_axis_vid_tvalid (tvalid),
        .s_axis_vid_tready (tready),
        .s_axis_vid_tuser  (tuser),
        .s_axis_vid_tlast  (tlast),
        .vid_data          (vid_data),
        .vid_de            (vid_de),
        .vid_hsync         (vid_hsync),
        .vid_vsync         (vid_vsync),
        .locked            (locked),
        .underflow         (underflow),
        .line_err          (line_err)
`ifdef VID_OUT_ERR_CNT_EN
        ,
        .err_count         (err_count)
`endif
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic        tuser;
        logic        tlast;
        logic [23:0] rgb;
    } beat_t;

    typedef struct packed {
        logic        tready;
        logic        de;
        logic        hs;
        logic        vs;
        logic [23:0] data;
        logic        locked;
        logic        uf;
        logic        lerr;
        logic [15:0] ec;
    } obs_t;

    obs_t  exp_q[$];
    beat_t mq[$];
    bit    m_seek, m_armed, m_run, m_en, m_uf, m_tready;
    int    m_h, m_v, m_errs;
    int    tests = 0;
    int    fails = 0;

    int          src_px, src_frame;
    logic [31:0] src_data;
    int          corrupt_frame = 3;
    int          inject_frame = 5;

    function automatic obs_t rst_obs();
        obs_t o;
        o = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        return o;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_seek = 1'b1; m_armed = 1'b0; m_run = 1'b0; m_en = 1'b0;
        m_uf = 1'b0; m_tready = 1'b0; m_h = 0; m_v = 0; m_errs = 0;
    endtask

    task automatic src_advance();
        src_px++;
        if (src_px == FRAME_PX) begin
            src_px = 0;
            src_frame++;
        end
        src_data = $urandom();
    endtask

    task automatic drive_inputs(input bit valid);
        tvalid = valid;
        tdata  = src_data;
        tuser  = (src_px == 0) || (src_frame == inject_frame && src_px == 2 * HA);
        if (src_frame == corrupt_frame && src_px / HA == 1) tlast = (src_px % HA == 5);
        else                                                tlast = (src_px % HA == HA - 1);
    endtask

    // One clock edge of the reference: raster position from cycle arithmetic, FIFO as a queue.
    task automatic model_edge();
        obs_t  o;
        beat_t b;
        bit    act, flush, acc, n_seek, n_armed, n_run;
        acc   = tvalid && m_tready;
        act   = (m_h < HA) && (m_v < VA);
        flush = 1'b0;
        o     = '0;
        o.de  = act;
        o.hs  = !((m_h >= HA + HF) && (m_h < HA + HF + HS));
        o.vs  = !((m_v >= VA + VF) && (m_v < VA + VF + VS));
        if (m_run && act) begin
            if (mq.size() == 0) begin
                m_uf = 1'b1; flush = 1'b1; m_errs++;
            end else if (mq[0].tuser != (m_h == 0 && m_v == 0)) begin
                flush = 1'b1; m_errs++;
            end else begin
                o.data = mq[0].rgb;
                o.lerr = (mq[0].tlast != (m_h == HA - 1));
                if (o.lerr) m_errs++;
                void'(mq.pop_front());
            end
        end
        n_seek = m_seek; n_armed = m_armed; n_run = m_run;
        b.tuser = tuser; b.tlast = tlast; b.rgb = tdata[23:0];
        if (acc) begin
            if (m_seek) begin
                if (tuser) begin
                    mq.push_back(b); n_seek = 1'b0; n_armed = 1'b1;
                end
            end else if (!flush) begin
                mq.push_back(b);
            end
            src_advance();
        end
        if (m_armed && m_h == HT - 1 && m_v == VT - 1) begin
            n_armed = 1'b0; n_run = 1'b1;
        end
        if (flush) begin
            mq.delete(); n_seek = 1'b1; n_armed = 1'b0; n_run = 1'b0;
        end
        m_seek = n_seek; m_armed = n_armed; m_run = n_run; m_en = 1'b1;
        m_h++;
        if (m_h == HT) begin
            m_h = 0;
            m_v = (m_v == VT - 1) ? 0 : m_v + 1;
        end
        m_tready = m_en && (m_seek || mq.size() < DEPTH);
        o.tready = m_tready;
        o.locked = m_run;
        o.uf     = m_uf;
        o.ec     = (m_errs > 65535) ? 16'hFFFF : 16'(m_errs);
        exp_q.push_back(o);
    endtask

    task automatic tick(input bit valid);
        @(posedge aclk);
        model_edge();
        #1;
        drive_inputs(valid);
    endtask

    task automatic run_until_pos(input int h, input int v, input int budget, input string name);
        int n;
        n = 0;
        while (!(m_h == h && m_v == v && m_run) && n < budget) begin
            tick(1'b1);
            n++;
        end
        if (n >= budget) begin
            tests++;
            fails++;
            $display("FAIL %s: model not running at (%0d,%0d) within %0d cycles", name, h, v, budget);
        end
    endtask

    task automatic reset_mid();
        @(posedge aclk);
        if (tvalid && m_tready) src_advance();
        #1;
        areset = 1'b1;
        model_reset();
        exp_q.push_back(rst_obs());
        repeat (2) begin
            @(posedge aclk);
            exp_q.push_back(rst_obs());
        end
        #1;
        areset = 1'b0;
        drive_inputs(1'b1);
    endtask

    initial begin : monitor
        obs_t e, a;
        forever begin
            @(negedge aclk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.tready = tready;   a.de = vid_de;   a.hs = vid_hsync; a.vs = vid_vsync;
                a.data   = vid_data; a.locked = locked; a.uf = underflow; a.lerr = line_err;
`ifdef VID_OUT_ERR_CNT_EN
                a.ec = err_count;
`else
                a.ec = '0;
                e.ec = '0;
`endif
                tests++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL out@%0t: got rdy=%b de=%b hs=%b vs=%b data=%h lock=%b uf=%b lerr=%b ec=%0d, want rdy=%b de=%b hs=%b vs=%b data=%h lock=%b uf=%b lerr=%b ec=%0d",
                             $time, a.tready, a.de, a.hs, a.vs, a.data, a.locked, a.uf, a.lerr, a.ec,
                             e.tready, e.de, e.hs, e.vs, e.data, e.locked, e.uf, e.lerr, e.ec);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stimulus
        // Three non-SOF beats precede the first frame.
        src_px    = FRAME_PX - 3;
        src_frame = -1;
        src_data  = $urandom();
        model_reset();
        areset = 1'b1;
        drive_inputs(1'b1);
        repeat (3) begin
            @(posedge aclk);
            exp_q.push_back(rst_obs());
        end
        #1;
        areset = 1'b0;
        drive_inputs(1'b1);

        // Lock, bad tlast line, stray tuser on line 2, relock.
        repeat (10 * FRAME_CYC) tick(1'b1);

        // Source stalls mid-line while running.
        run_until_pos(2, 1, 3 * FRAME_CYC, "stall_pos");
        repeat (20) tick(1'b0);
        repeat (4 * FRAME_CYC) tick(1'b1);

        // Random source gaps.
        repeat (3 * FRAME_CYC) tick($urandom_range(0, 3) != 0);

        // Reset mid-line, then relock.
        run_until_pos(3, 1, 4 * FRAME_CYC, "reset_pos");
        reset_mid();
        repeat (3 * FRAME_CYC) tick(1'b1);

        repeat (2) @(negedge aclk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
